// File: rtl/dm_responder.sv
// Data-memory responder for the MEM-stage port: one request at a time, WAIT_CYCLES wait states, word/half access.
// Define DM_WRITE_LOG_EN to print a simulation log line for every committed store.
module dm_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_half,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, half_q;
    logic [31:0] addr_q, wdata_q, pc_q;
    logic [31:0] mem [DEPTH];

    logic              accept;
    logic              mem_we;
    logic              resp_valid_d, resp_err_d;
    logic [31:0]       resp_rdata_d;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       cur_word, merged, load_data;
    logic [15:0]       sel_half;
    logic              misaligned, out_of_range, acc_err;

    assign req_ready = (state_q == S_IDLE);

    // Access decode works purely on the latched request, so late input changes cannot leak in.
    assign idx          = addr_q[ADDR_W+1:2];
    assign cur_word     = mem[idx];
    assign sel_half     = addr_q[1] ? cur_word[31:16] : cur_word[15:0];
    assign misaligned   = half_q ? addr_q[0] : (addr_q[1:0] != 2'b00);
    assign out_of_range = (addr_q >> (ADDR_W + 2)) != 32'd0;
    assign acc_err      = misaligned | out_of_range;
    assign load_data    = half_q ? {{16{sel_half[15]}}, sel_half} : cur_word;

    always_comb begin
        merged = wdata_q;
        if (half_q) begin
            merged = addr_q[1] ? {wdata_q[15:0], cur_word[15:0]}
                               : {cur_word[31:16], wdata_q[15:0]};
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        accept       = 1'b0;
        mem_we       = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = acc_err;
                    resp_rdata_d = (acc_err || write_q) ? 32'd0 : load_data;
                    mem_we       = write_q && !acc_err;
                    state_d      = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            write_q    <= 1'b0;
            half_q     <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            pc_q       <= 32'd0;
            // NOTE: the array is cleared on reset on purpose; a reset must also discard stored data.
            mem        <= '{default: '0};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= resp_rdata_d;
            resp_err   <= resp_err_d;
            if (accept) begin
                write_q <= req_write;
                half_q  <= req_half;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                pc_q    <= req_pc;
            end
            if (mem_we) begin
                mem[idx] <= merged;
            end
        end
    end

`ifdef DM_WRITE_LOG_EN
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            $display("@%h: *%h <= %h", pc_q, {addr_q[31:2], 2'b00}, merged);
        end
    end
`else
    // The PC is only consumed by the write log.
    logic unused_pc;
    assign unused_pc = ^pc_q;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder (ADDR_W=10, WAIT_CYCLES=2).
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_half;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int errors = 0;
    int checks = 0;

    dm_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_half   (req_half),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    // Issues one request from the post-edge sample phase and returns the response.
    // After the accept edge the inputs are scrambled to show the request was latched.
    task automatic do_req(input logic wr, input logic hf, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic er, output int lat, output int plen);
        rd   = 32'd0;
        er   = 1'b0;
        lat  = -1;
        plen = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_half  = hf;
        req_addr  = a;
        req_wdata = wd;
        req_pc    = 32'h0040_0000 + a;
        for (int t = 0; t < 20 && !req_ready; t++) begin
            @(posedge clk); #1;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = ~wr;
        req_half  = ~hf;
        req_addr  = ~a;
        req_wdata = ~wd;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (resp_valid) begin
                lat = k;
                rd  = resp_rdata;
                er  = resp_err;
                break;
            end
        end
        if (lat < 0) return;
        plen = 1;
        @(posedge clk); #1;
        while (resp_valid && plen < 4) begin
            plen++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_half  = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_pc    = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", resp_valid); end
        checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", resp_err); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word();
        logic [31:0] rd;
        logic        er;
        int          lat, plen;
        do_req(1'b1, 1'b0, 32'h10, 32'h1234_5678, rd, er, lat, plen);
        checks++; if (lat !== 3) begin errors++; $display("FAIL word_store_latency: got %0d expected 3", lat); end
        checks++; if (plen !== 1) begin errors++; $display("FAIL word_store_pulse: got %0d expected 1", plen); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL word_store_err: got %b expected 0", er); end
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL word_store_rdata: got %h expected 0", rd); end
        do_req(1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat, plen);
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL word_load: got %h expected 12345678", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL word_load_err: got %b expected 0", er); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL word_load_latency: got %0d expected 3", lat); end
        do_req(1'b1, 1'b0, 32'hFFC, 32'hCAFE_F00D, rd, er, lat, plen);
        do_req(1'b0, 1'b0, 32'hFFC, 32'h0, rd, er, lat, plen);
        checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL top_word_load: got %h expected cafef00d", rd); end
    endtask

    task automatic test_half();
        logic [31:0] rd;
        logic        er;
        int          lat, plen;
        do_req(1'b1, 1'b1, 32'h12, 32'h1234_BEEF, rd, er, lat, plen);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL half_store_err: got %b expected 0", er); end
        do_req(1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat, plen);
        checks++; if (rd !== 32'hBEEF_5678) begin errors++; $display("FAIL half_merged_word: got %h expected beef5678", rd); end
        do_req(1'b0, 1'b1, 32'h12, 32'h0, rd, er, lat, plen);
        checks++; if (rd !== 32'hFFFF_BEEF) begin errors++; $display("FAIL half_load_hi: got %h expected ffffbeef", rd); end
        do_req(1'b0, 1'b1, 32'h10, 32'h0, rd, er, lat, plen);
        checks++; if (rd !== 32'h0000_5678) begin errors++; $display("FAIL half_load_lo: got %h expected 00005678", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er;
        int          lat, plen;
        do_req(1'b0, 1'b0, 32'h11, 32'h0, rd, er, lat, plen);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL misaligned_word_err: got %b expected 1", er); end
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL misaligned_word_rdata: got %h expected 0", rd); end
        do_req(1'b1, 1'b1, 32'h13, 32'h0000_1111, rd, er, lat, plen);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL misaligned_half_err: got %b expected 1", er); end
        checks++; if (plen !== 1) begin errors++; $display("FAIL misaligned_half_pulse: got %0d expected 1", plen); end
        do_req(1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat, plen);
        checks++; if (rd !== 32'hBEEF_5678) begin errors++; $display("FAIL after_errors_word: got %h expected beef5678", rd); end
        do_req(1'b1, 1'b0, 32'h1000, 32'hDEAD_BEEF, rd, er, lat, plen);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL out_of_range_err: got %b expected 1", er); end
        do_req(1'b0, 1'b0, 32'h0, 32'h0, rd, er, lat, plen);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL word0_untouched: got %h expected 0", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL word0_err: got %b expected 0", er); end
        do_req(1'b0, 1'b0, 32'h8000_0010, 32'h0, rd, er, lat, plen);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL high_bit_err: got %b expected 1", er); end
    endtask

    task automatic test_back_to_back();
        int   acc_at[$];
        int   pulses = 0;
        int   doubles = 0;
        logic prev = 1'b0;
        req_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            req_write = 1'b0;
            req_half  = 1'b0;
            req_addr  = 32'(c * 4);
            if (req_ready) acc_at.push_back(c);
            if (resp_valid) pulses++;
            if (resp_valid && prev) doubles++;
            prev = resp_valid;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        checks++; if (acc_at.size() !== 4) begin errors++; $display("FAIL b2b_accepts: got %0d expected 4", acc_at.size()); end
        for (int i = 1; i < acc_at.size(); i++) begin
            checks++;
            if (acc_at[i] - acc_at[i-1] !== 5) begin
                errors++; $display("FAIL b2b_spacing: got %0d expected 5", acc_at[i] - acc_at[i-1]);
            end
        end
        checks++; if (pulses !== 3) begin errors++; $display("FAIL b2b_pulses: got %0d expected 3", pulses); end
        checks++; if (doubles !== 0) begin errors++; $display("FAIL b2b_pulse_width: got %0d expected 0", doubles); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd;
        logic        er;
        int          lat, plen;
        int          seen = 0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_half  = 1'b0;
        req_addr  = 32'h20;
        req_wdata = 32'hAAAA_AAAA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        if (resp_valid) seen++;
        reset = 1'b1;
        @(posedge clk); #1;
        if (resp_valid) seen++;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", req_ready); end
        repeat (4) begin
            if (resp_valid) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_response: got %0d expected 0", seen); end
        do_req(1'b0, 1'b0, 32'h20, 32'h0, rd, er, lat, plen);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL abort_no_write: got %h expected 0", rd); end
        do_req(1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat, plen);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_clears_mem: got %h expected 0", rd); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_half();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
